// File: rtl/pattern_apply_checker_pkg.sv
// Shared types and helpers for the pattern applier / response checker.
// Holds the run FSM encoding and the settle-counter width function.
package pat_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PAT,
    FORCE,
    SETTLE,
    MEASURE,
    DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pattern_apply_checker_if.sv
// Pattern-stream handshake between a pattern source (ROM/DMA) and the checker.
// The source is the master; the checker consumes beats as the slave.
interface pattern_apply_checker_if #(
  parameter int unsigned NINPUTS  = 5,
  parameter int unsigned NOUTPUTS = 2
);

  logic                pat_valid;
  logic                pat_ready;
  logic [NINPUTS-1:0]  pat_pi;
  logic [NOUTPUTS-1:0] pat_xpct;
  logic [NOUTPUTS-1:0] pat_mask;
  logic                pat_last;

  modport master (
    output pat_valid,
    input  pat_ready,
    output pat_pi,
    output pat_xpct,
    output pat_mask,
    output pat_last
  );

  modport slave (
    input  pat_valid,
    output pat_ready,
    input  pat_pi,
    input  pat_xpct,
    input  pat_mask,
    input  pat_last
  );

endinterface

// File: rtl/pattern_apply_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_apply_checker.sv
// Pattern applier / response checker: drives each PI vector, waits CAPTURE_DLY cycles,
// compares masked POs and keeps pattern/fail counts plus first-fail diagnostics.
module pattern_apply_checker
  import pat_chk_pkg::*;
#(
  parameter int unsigned NINPUTS     = 5,
  parameter int unsigned NOUTPUTS    = 2,
  parameter int unsigned CAPTURE_DLY = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  pattern_apply_checker_if.slave pat,
  output logic [NINPUTS-1:0]  dut_pi,
  input  logic [NOUTPUTS-1:0] dut_po,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pat_count,
  output logic [CNT_W-1:0]    fail_count,
  output logic                first_fail_vld,
  output logic [CNT_W-1:0]    first_fail_idx,
  output logic [NOUTPUTS-1:0] first_fail_bits
);

  localparam int unsigned SW = clog2(CAPTURE_DLY + 1);

  state_e              state, nxt;
  logic [SW-1:0]       settle_cnt;
  logic [NINPUTS-1:0]  pi_q;
  logic [NOUTPUTS-1:0] xpct_q;
  logic [NOUTPUTS-1:0] mask_q;
  logic                last_q;
  logic [NOUTPUTS-1:0] miss;
  logic                run_start;
  logic                accept;
  logic                measure;
  logic                hit;

  // Masked-off bits are forced to 0, so X on a don't-care PO cannot register a miss.
  assign miss      = (xpct_q ^ dut_po) & mask_q;
  assign hit       = |miss;
  assign run_start = start && ((state == IDLE) || (state == DONE));
  assign accept    = (state == WAIT_PAT) && pat.pat_valid;
  assign measure   = (state == MEASURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt           = state;
    pat.pat_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) nxt = WAIT_PAT;
      end
      WAIT_PAT: begin
        pat.pat_ready = 1'b1;
        busy          = 1'b1;
        if (pat.pat_valid) nxt = FORCE;
      end
      FORCE: begin
        busy = 1'b1;
        nxt  = (CAPTURE_DLY == 1) ? MEASURE : SETTLE;
      end
      // SETTLE spans CAPTURE_DLY-1 cycles: leave when the decrement reaches zero.
      SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == SW'(1)) nxt = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        nxt  = last_q ? DONE : WAIT_PAT;
      end
      DONE: begin
        done = 1'b1;
        if (start) nxt = WAIT_PAT;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_q       <= '0;
      xpct_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      dut_pi     <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) begin
        pi_q   <= pat.pat_pi;
        xpct_q <= pat.pat_xpct;
        mask_q <= pat.pat_mask;
        last_q <= pat.pat_last;
      end
      if (state == FORCE) begin
        dut_pi     <= pi_q;
        settle_cnt <= SW'(CAPTURE_DLY - 1);
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt - SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld  <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_bits <= '0;
    end else if (run_start) begin
      first_fail_vld  <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_bits <= '0;
    end else if (measure && hit && !first_fail_vld) begin
      first_fail_vld  <= 1'b1;
      first_fail_idx  <= pat_count;
      first_fail_bits <= miss;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_pat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (run_start),
    .inc   (measure),
    .q     (pat_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (run_start),
    .inc   (measure && hit),
    .q     (fail_count)
  );

endmodule

// File: tb/tb_pattern_apply_checker.sv
// Directed bench for pattern_apply_checker: main instance (CNT_W=16, CAPTURE_DLY=2)
// and a narrow-counter instance (CNT_W=2) for saturation.
module tb_pattern_apply_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [4:0]  dut_pi, dut_pi2;
  logic [1:0]  dut_po = 2'b00;
  logic [1:0]  dut_po2 = 2'b00;
  logic        busy, done, ffv;
  logic [15:0] pat_count, fail_count, ff_idx;
  logic [1:0]  ff_bits;
  logic        busy2, done2, ffv2;
  logic [1:0]  pat_count2, fail_count2, ff_idx2;
  logic [1:0]  ff_bits2;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pattern_apply_checker_if #(.NINPUTS(5), .NOUTPUTS(2)) pif ();
  pattern_apply_checker_if #(.NINPUTS(5), .NOUTPUTS(2)) pif2 ();

  pattern_apply_checker #(.NINPUTS(5), .NOUTPUTS(2), .CAPTURE_DLY(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pif.slave),
    .dut_pi(dut_pi), .dut_po(dut_po), .busy(busy), .done(done),
    .pat_count(pat_count), .fail_count(fail_count), .first_fail_vld(ffv),
    .first_fail_idx(ff_idx), .first_fail_bits(ff_bits)
  );

  pattern_apply_checker #(.NINPUTS(5), .NOUTPUTS(2), .CAPTURE_DLY(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pat(pif2.slave),
    .dut_pi(dut_pi2), .dut_po(dut_po2), .busy(busy2), .done(done2),
    .pat_count(pat_count2), .fail_count(fail_count2), .first_fail_vld(ffv2),
    .first_fail_idx(ff_idx2), .first_fail_bits(ff_bits2)
  );

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start  = 1'b0;
  endtask

  // Waits for pat_ready, presents one beat, returns at the negedge after the accepting edge.
  task automatic send(input bit sel, input logic [4:0] pi, input logic [1:0] x,
                      input logic [1:0] m, input logic last, input logic [1:0] po);
    int unsigned t;
    logic rdy;
    t = 0;
    rdy = sel ? pif2.pat_ready : pif.pat_ready;
    while (rdy !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
      rdy = sel ? pif2.pat_ready : pif.pat_ready;
    end
    n_checks++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL send_ready_timeout: pat_ready=%b after %0d cycles, required 1", rdy, t);
    end
    if (sel) begin
      dut_po2 = po; pif2.pat_pi = pi; pif2.pat_xpct = x; pif2.pat_mask = m;
      pif2.pat_last = last; pif2.pat_valid = 1'b1;
    end else begin
      dut_po = po; pif.pat_pi = pi; pif.pat_xpct = x; pif.pat_mask = m;
      pif.pat_last = last; pif.pat_valid = 1'b1;
    end
    @(negedge clk);
    pif.pat_valid  = 1'b0;
    pif2.pat_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int unsigned t;
    logic d;
    t = 0;
    d = sel ? done2 : done;
    while (d !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
      d = sel ? done2 : done;
    end
    n_checks++;
    if (d !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", d, t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_checks++; if (pif.pat_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", pif.pat_ready); end
    n_checks++; if (pat_count !== 16'd0) begin n_fail++; $display("FAIL rst_pat_count: got %0d want 0", pat_count); end
    n_checks++; if (fail_count !== 16'd0) begin n_fail++; $display("FAIL rst_fail_count: got %0d want 0", fail_count); end
    n_checks++; if (ffv !== 1'b0 || ff_idx !== 16'd0 || ff_bits !== 2'b00) begin
      n_fail++; $display("FAIL rst_first_fail: got vld=%b idx=%0d bits=%b want 0/0/00", ffv, ff_idx, ff_bits); end
    n_checks++; if (dut_pi !== 5'b00000) begin n_fail++; $display("FAIL rst_dut_pi: got %b want 00000", dut_pi); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || pif.pat_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_rst: got busy=%b ready=%b want 0/0", busy, pif.pat_ready); end
  endtask

  task automatic test_single();
    pulse_start(1'b0);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: got busy=%b done=%b want 1/0", busy, done); end
    send(1'b0, 5'b01011, 2'b01, 2'b01, 1'b1, 2'b11);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd1) begin n_fail++; $display("FAIL single_pat_count: got %0d want 1", pat_count); end
    n_checks++; if (fail_count !== 16'd0) begin n_fail++; $display("FAIL single_fail_count: got %0d want 0", fail_count); end
    n_checks++; if (ffv !== 1'b0) begin n_fail++; $display("FAIL single_ffv: got %b want 0", ffv); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_checks++; if (dut_pi !== 5'b01011 || done !== 1'b1) begin
      n_fail++; $display("FAIL single_hold: got dut_pi=%b done=%b want 01011/1", dut_pi, done); end
  endtask

  task automatic test_two_patterns();
    pulse_start(1'b0);
    n_checks++; if (done !== 1'b0 || pat_count !== 16'd0) begin
      n_fail++; $display("FAIL two_restart: got done=%b pat_count=%0d want 0/0", done, pat_count); end
    send(1'b0, 5'b01011, 2'b01, 2'b01, 1'b0, 2'b01);
    send(1'b0, 5'b01001, 2'b00, 2'b01, 1'b1, 2'b01);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd2) begin n_fail++; $display("FAIL two_pat_count: got %0d want 2", pat_count); end
    n_checks++; if (fail_count !== 16'd1) begin n_fail++; $display("FAIL two_fail_count: got %0d want 1", fail_count); end
    n_checks++; if (ffv !== 1'b1 || ff_idx !== 16'd1 || ff_bits !== 2'b01) begin
      n_fail++; $display("FAIL two_first_fail: got vld=%b idx=%0d bits=%b want 1/1/01", ffv, ff_idx, ff_bits); end
  endtask

  // PO is correct only in the cycle ending at accept+3, so any other sample edge records a fail.
  task automatic test_latency();
    pulse_start(1'b0);
    send(1'b0, 5'b10110, 2'b10, 2'b11, 1'b0, 2'b01);
    n_checks++; if (dut_pi !== 5'b01001) begin n_fail++; $display("FAIL lat_pi_e0: got %b want 01001", dut_pi); end
    @(negedge clk);
    n_checks++; if (dut_pi !== 5'b10110) begin n_fail++; $display("FAIL lat_pi_e1: got %b want 10110", dut_pi); end
    @(negedge clk);
    dut_po = 2'b10;
    n_checks++; if (pat_count !== 16'd0) begin n_fail++; $display("FAIL lat_count_e2: got %0d want 0", pat_count); end
    @(negedge clk);
    dut_po = 2'b01;
    n_checks++; if (pat_count !== 16'd1) begin n_fail++; $display("FAIL lat_count_e3: got %0d want 1", pat_count); end
    n_checks++; if (fail_count !== 16'd0) begin n_fail++; $display("FAIL lat_sample_edge: fail_count got %0d want 0", fail_count); end
    n_checks++; if (pif.pat_ready !== 1'b1) begin n_fail++; $display("FAIL lat_throughput: ready got %b want 1", pif.pat_ready); end
    send(1'b0, 5'b10110, 2'b10, 2'b11, 1'b1, 2'b10);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd2 || fail_count !== 16'd0) begin
      n_fail++; $display("FAIL lat_final: got pat=%0d fail=%0d want 2/0", pat_count, fail_count); end
  endtask

  task automatic test_mask();
    pulse_start(1'b0);
    send(1'b0, 5'b00000, 2'b11, 2'b10, 1'b0, 2'b1x);
    send(1'b0, 5'b11111, 2'b01, 2'b00, 1'b1, 2'bxx);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd2 || fail_count !== 16'd0 || ffv !== 1'b0) begin
      n_fail++; $display("FAIL mask_dont_care: got pat=%0d fail=%0d vld=%b want 2/0/0", pat_count, fail_count, ffv); end
  endtask

  task automatic test_reset_mid_run();
    pulse_start(1'b0);
    send(1'b0, 5'b01011, 2'b01, 2'b01, 1'b0, 2'b01);
    send(1'b0, 5'b01001, 2'b00, 2'b01, 1'b0, 2'b01);
    send(1'b0, 5'b11100, 2'b00, 2'b00, 1'b0, 2'b00);
    n_checks++; if (pat_count !== 16'd2 || fail_count !== 16'd1 || ffv !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_reset: got pat=%0d fail=%0d vld=%b want 2/1/1", pat_count, fail_count, ffv); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (pif.pat_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got ready=%b busy=%b done=%b want 0/0/0", pif.pat_ready, busy, done); end
    n_checks++; if (pat_count !== 16'd0 || fail_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_rst_counts: got pat=%0d fail=%0d want 0/0", pat_count, fail_count); end
    n_checks++; if (ffv !== 1'b0 || ff_idx !== 16'd0 || ff_bits !== 2'b00 || dut_pi !== 5'b00000) begin
      n_fail++; $display("FAIL mid_rst_diag: got vld=%b idx=%0d bits=%b pi=%b want 0/0/00/00000", ffv, ff_idx, ff_bits, dut_pi); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(1'b0);
    send(1'b0, 5'b01011, 2'b01, 2'b01, 1'b0, 2'b01);
    send(1'b0, 5'b11100, 2'b00, 2'b00, 1'b1, 2'b00);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd2 || fail_count !== 16'd0 || ffv !== 1'b0) begin
      n_fail++; $display("FAIL mid_rerun: got pat=%0d fail=%0d vld=%b want 2/0/0", pat_count, fail_count, ffv); end
  endtask

  task automatic test_stall_and_start();
    @(negedge clk);
    start = 1'b1;
    dut_po = 2'b01; pif.pat_pi = 5'b01011; pif.pat_xpct = 2'b01; pif.pat_mask = 2'b01;
    pif.pat_last = 1'b0; pif.pat_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pif.pat_valid = 1'b0;
    n_checks++; if (pif.pat_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL start_with_beat: got ready=%b busy=%b done=%b want 1/1/0", pif.pat_ready, busy, done); end
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (pif.pat_ready !== 1'b1 || pat_count !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got ready=%b pat=%0d busy=%b want 1/0/1", pif.pat_ready, pat_count, busy); end
    send(1'b0, 5'b01011, 2'b01, 2'b01, 1'b0, 2'b01);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || pif.pat_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_while_busy: got busy=%b ready=%b want 1/0", busy, pif.pat_ready); end
    send(1'b0, 5'b01001, 2'b00, 2'b01, 1'b1, 2'b01);
    wait_done(1'b0);
    n_checks++; if (pat_count !== 16'd2 || fail_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_counts: got pat=%0d fail=%0d want 2/1", pat_count, fail_count); end
    n_checks++; if (ffv !== 1'b1 || ff_idx !== 16'd1 || ff_bits !== 2'b01) begin
      n_fail++; $display("FAIL stall_first_fail: got vld=%b idx=%0d bits=%b want 1/1/01", ffv, ff_idx, ff_bits); end
  endtask

  task automatic test_saturate();
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 5'(i), 2'b00, 2'b11, (i == 4), 2'b11);
    end
    wait_done(1'b1);
    n_checks++; if (pat_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_pat_count: got %0d want 3", pat_count2); end
    n_checks++; if (fail_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_fail_count: got %0d want 3", fail_count2); end
    n_checks++; if (ffv2 !== 1'b1 || ff_idx2 !== 2'd0 || ff_bits2 !== 2'b11) begin
      n_fail++; $display("FAIL sat_first_fail: got vld=%b idx=%0d bits=%b want 1/0/11", ffv2, ff_idx2, ff_bits2); end
  endtask

  initial begin
    pif.pat_valid = 1'b0; pif.pat_pi = '0; pif.pat_xpct = '0; pif.pat_mask = '0; pif.pat_last = 1'b0;
    pif2.pat_valid = 1'b0; pif2.pat_pi = '0; pif2.pat_xpct = '0; pif2.pat_mask = '0; pif2.pat_last = 1'b0;
    test_reset();
    test_single();
    test_two_patterns();
    test_latency();
    test_mask();
    test_reset_mid_run();
    test_stall_and_start();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
